fifo_burst_reader: RTL and testbench

Read-side consumer of the sample dual-clock FIFO, running entirely in the outputClock domain.
- Waits until the FIFO holds at least one burst of samples and the downstream USB slave-FIFO bridge reports space.
- Drains exactly BURST_LEN words through the show-ahead read port, zero-extends each 10-bit sample to the 16-bit bus, and marks the last word of each burst.
- Provides a test-pattern mode and a sticky underrun flag for capture-integrity checks.

---
 rtl/fifo_burst_reader_pkg.sv | 21 ++
 rtl/fifo_burst_reader_if.sv | 30 +++
 rtl/fifo_burst_reader_test_pattern_gen.sv | 33 +++
 rtl/fifo_burst_reader.sv | 119 +++++++++++
 tb/tb_fifo_burst_reader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader: FSM states, default
// burst/gap sizing and the counter-width helper.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 10;
    localparam int DEFAULT_BUS_WIDTH  = 16;
    localparam int DEFAULT_BURST_LEN  = 4096;
    localparam int DEFAULT_GAP_CYCLES = 4;

    // Width of a down-counter that has to hold values 0..n-1.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus downstream host bus of the burst reader. The master
// modport is the reader; the slave modport is the FIFO/host environment.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 10,
    parameter int BUS_WIDTH  = 16
);

    logic [DATA_WIDTH-1:0] fifoData;
    logic                  fifoEmpty;
    logic                  fifoHalfFull;
    logic                  fifoAck;
    logic                  hostReady;
    logic [BUS_WIDTH-1:0]  hostData;
    logic                  hostWrite;
    logic                  packetEnd;
    logic                  testMode;
    logic                  clearErrors;
    logic                  underrun;

    modport master (
        input  fifoData, fifoEmpty, fifoHalfFull, hostReady, testMode, clearErrors,
        output fifoAck, hostData, hostWrite, packetEnd, underrun
    );

    modport slave (
        output fifoData, fifoEmpty, fifoHalfFull, hostReady, testMode, clearErrors,
        input  fifoAck, hostData, hostWrite, packetEnd, underrun
    );

endinterface

// File: rtl/fifo_burst_reader_test_pattern_gen.sv
// Wrapping test-pattern counter; advances once per word emitted in test mode.
module test_pattern_gen #(
    parameter int WIDTH = 10
) (
    input  logic             outputClock,
    input  logic             nReset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses <= so all flops update together from pre-edge values.
    always_ff @(posedge outputClock or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains fixed-length bursts from a show-ahead FIFO onto the host bus,
// with a counter test-pattern source and a sticky underrun flag.
module fifo_burst_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input logic                 outputClock,
    input logic                 nReset,
    fifo_burst_reader_if.master bus
);

    localparam int CNT_W = count_width(BURST_LEN);
    localparam int GAP_W = count_width(GAP_CYCLES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  test_src_q, test_src_d;
    logic [BUS_WIDTH-1:0]  host_data_q, host_data_d;
    logic                  host_write_q, host_write_d;
    logic                  packet_end_q, packet_end_d;
    logic                  underrun_q, underrun_d;

    logic                  in_burst;
    logic                  take;
    logic                  starve;
    logic [DATA_WIDTH-1:0] test_count;

    // The source is latched at burst start, so testMode toggling mid-burst
    // can never pop the FIFO during a counter burst or vice versa.
    assign in_burst    = (state_q == BURST);
    assign take        = in_burst && bus.hostReady && (test_src_q || !bus.fifoEmpty);
    assign starve      = in_burst && bus.hostReady && !test_src_q && bus.fifoEmpty;
    assign bus.fifoAck = in_burst && bus.hostReady && !test_src_q && !bus.fifoEmpty;

    test_pattern_gen #(
        .WIDTH (DATA_WIDTH)
    ) u_test_pattern_gen (
        .outputClock (outputClock),
        .nReset      (nReset),
        .en          (take && test_src_q),
        .count       (test_count)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        gap_d        = gap_q;
        test_src_d   = test_src_q;
        host_data_d  = host_data_q;
        host_write_d = 1'b0;
        packet_end_d = 1'b0;
        // A starve event on the same edge as clearErrors keeps the flag set.
        underrun_d   = starve ? 1'b1 : (bus.clearErrors ? 1'b0 : underrun_q);

        case (state_q)
            IDLE: begin
                if (bus.hostReady && (bus.testMode || bus.fifoHalfFull)) begin
                    state_d     = BURST;
                    remaining_d = CNT_W'(BURST_LEN - 1);
                    test_src_d  = bus.testMode;
                end
            end
            BURST: begin
                if (take) begin
                    host_data_d  = test_src_q ? BUS_WIDTH'(test_count) : BUS_WIDTH'(bus.fifoData);
                    host_write_d = 1'b1;
                    packet_end_d = (remaining_q == '0);
                    if (remaining_q == '0) begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge outputClock or negedge nReset) begin
        if (!nReset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            gap_q        <= '0;
            test_src_q   <= 1'b0;
            host_data_q  <= '0;
            host_write_q <= 1'b0;
            packet_end_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            gap_q        <= gap_d;
            test_src_q   <= test_src_d;
            host_data_q  <= host_data_d;
            host_write_q <= host_write_d;
            packet_end_q <= packet_end_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.hostData  = host_data_q;
    assign bus.hostWrite = host_write_q;
    assign bus.packetEnd = packet_end_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO/host environment, a word-count
// reference model compared every cycle, and directed plus random scenarios.
module tb_fifo_burst_reader;

    localparam int DW = 10;
    localparam int BW = 16;
    localparam int BL = 8;
    localparam int GC = 4;

    logic outputClock = 1'b0;
    logic nReset      = 1'b0;

    always #5 outputClock = ~outputClock;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .BURST_LEN  (BL),
        .GAP_CYCLES (GC)
    ) dut (
        .outputClock (outputClock),
        .nReset      (nReset),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] env_q[$];   // words held by the FIFO environment
    logic [DW-1:0] exp_q[$];   // same words as the model expects to consume them
    logic [BW:0]   cap[$];     // captured host words {packetEnd, hostData}
    bit            force_hf = 1'b0;
    logic          ack_s    = 1'b0;

    // Reference model: burst in progress, words taken so far, gap cycles left.
    bit            m_busy  = 1'b0;
    int            m_taken = 0;
    int            m_gap   = 0;
    bit            m_src   = 1'b0;
    int            m_tc    = 0;
    logic [BW-1:0] e_data  = '0;
    bit            e_write = 1'b0;
    bit            e_end   = 1'b0;
    bit            e_under = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh_fifo();
        bus.fifoEmpty    = (env_q.size() == 0);
        bus.fifoData     = (env_q.size() == 0) ? '0 : env_q[0];
        bus.fifoHalfFull = force_hf || (env_q.size() >= BL);
    endtask

    // FIFO environment: pop on the edge where the acknowledge was high.
    always @(posedge outputClock) begin
        if (ack_s && env_q.size() != 0) void'(env_q.pop_front());
        #2 refresh_fifo();
    end

    // Compare process: registered outputs against the model, then advance the model.
    always @(negedge outputClock) begin : cmp
        bit hr;
        bit fe;
        bit take;
        bit starve;
        if (!nReset) begin
            m_busy  = 1'b0;
            m_taken = 0;
            m_gap   = 0;
            m_src   = 1'b0;
            m_tc    = 0;
            e_write = 1'b0;
            e_end   = 1'b0;
            e_under = 1'b0;
            ack_s   = 1'b0;
            check("reset_hostWrite", bus.hostWrite, 0);
            check("reset_packetEnd", bus.packetEnd, 0);
            check("reset_hostData", bus.hostData, 0);
            check("reset_underrun", bus.underrun, 0);
            check("reset_fifoAck", bus.fifoAck, 0);
        end else begin
            check("hostWrite", bus.hostWrite, e_write);
            check("packetEnd", bus.packetEnd, e_end);
            if (e_write) check("hostData", bus.hostData, e_data);
            check("underrun", bus.underrun, e_under);
            if (bus.hostWrite) cap.push_back({bus.packetEnd, bus.hostData});

            hr = bus.hostReady;
            fe = bus.fifoEmpty;
            check("fifoAck", bus.fifoAck, m_busy && !m_src && hr && !fe);
            ack_s = bus.fifoAck;

            take    = m_busy && hr && (m_src || !fe);
            starve  = m_busy && hr && !m_src && fe;
            e_write = 1'b0;
            e_end   = 1'b0;
            if (m_busy) begin
                if (take) begin
                    if (m_src) begin
                        e_data = BW'(m_tc);
                        m_tc   = (m_tc + 1) % (1 << DW);
                    end else begin
                        e_data = (exp_q.size() != 0) ? BW'(exp_q.pop_front()) : 'x;
                    end
                    e_write = 1'b1;
                    m_taken++;
                    if (m_taken == BL) begin
                        e_end  = 1'b1;
                        m_busy = 1'b0;
                        m_gap  = GC;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (hr && (bus.testMode || bus.fifoHalfFull)) begin
                m_busy  = 1'b1;
                m_taken = 0;
                m_src   = bus.testMode;
            end
            if (starve) e_under = 1'b1;
            else if (bus.clearErrors) e_under = 1'b0;
        end
    end

    task automatic tick();
        @(posedge outputClock);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        env_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_cap(input int n, input int budget, input string name);
        int c = 0;
        while (cap.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(name, cap.size(), n);
    endtask

    task automatic wait_writes(input int k, input int budget, input string name);
        int cnt = 0;
        int c = 0;
        while (cnt < k && c < budget) begin
            tick();
            c++;
            if (bus.hostWrite) cnt++;
        end
        check(name, cnt, k);
    endtask

    initial begin
        bus.hostReady   = 1'b0;
        bus.testMode    = 1'b0;
        bus.clearErrors = 1'b0;
        refresh_fifo();
        repeat (3) tick();

        // Two back-to-back bursts from 0x001..0x010.
        for (int i = 1; i <= 16; i++) push_word(DW'(i));
        bus.hostReady = 1'b1;
        nReset = 1'b1;
        wait_cap(16, 200, "t1_word_count");
        if (cap.size() >= 16) begin
            for (int i = 0; i < 8; i++) begin
                check("t1_data", cap[i][BW-1:0], i + 1);
                check("t1_end", cap[i][BW], (i == 7));
            end
            check("t1_second_burst_first", cap[8][BW-1:0], 16'h0009);
            check("t1_second_burst_end", cap[15][BW], 1);
        end
        repeat (10) tick();

        // Host stalls for 3 cycles after the third word.
        cap.delete();
        for (int i = 0; i < 8; i++) push_word(DW'(12'h020 + i));
        wait_writes(3, 100, "t2_three_words");
        bus.hostReady = 1'b0;
        repeat (3) begin
            tick();
            check("t2_stall_ack", bus.fifoAck, 0);
            check("t2_stall_write", bus.hostWrite, 0);
        end
        bus.hostReady = 1'b1;
        wait_cap(8, 100, "t2_word_count");
        repeat (10) tick();
        check("t2_exactly_eight", cap.size(), 8);
        if (cap.size() >= 8) begin
            check("t2_fourth_word", cap[3][BW-1:0], 16'h0023);
            check("t2_last_end", cap[7], {1'b1, 16'h0027});
        end

        // Burst forced to start with only 5 words queued.
        cap.delete();
        force_hf = 1'b1;
        for (int i = 0; i < 5; i++) push_word(DW'(12'h030 + i));
        for (int c = 0; c < 100 && !bus.underrun; c++) tick();
        force_hf = 1'b0;
        check("t3_underrun_set", bus.underrun, 1);
        check("t3_words_before_stall", cap.size(), 5);
        repeat (3) tick();
        check("t3_stalled", cap.size(), 5);
        for (int i = 5; i < 8; i++) push_word(DW'(12'h030 + i));
        wait_cap(8, 100, "t3_word_count");
        if (cap.size() >= 8) begin
            check("t3_sixth_word", cap[5][BW-1:0], 16'h0035);
            check("t3_last_end", cap[7], {1'b1, 16'h0037});
        end
        check("t3_underrun_sticky", bus.underrun, 1);
        bus.clearErrors = 1'b1;
        tick();
        bus.clearErrors = 1'b0;
        check("t3_underrun_cleared", bus.underrun, 0);
        repeat (10) tick();

        // clearErrors held while new underrun events keep occurring.
        cap.delete();
        force_hf = 1'b1;
        bus.clearErrors = 1'b1;
        push_word(10'h050);
        push_word(10'h051);
        wait_cap(2, 100, "t6_two_words");
        force_hf = 1'b0;
        repeat (4) tick();
        check("t6_set_wins", bus.underrun, 1);
        bus.clearErrors = 1'b0;
        for (int i = 2; i < 8; i++) push_word(DW'(12'h050 + i));
        wait_cap(8, 100, "t6_word_count");
        if (cap.size() >= 8) check("t6_last_end", cap[7], {1'b1, 16'h0057});
        bus.clearErrors = 1'b1;
        tick();
        bus.clearErrors = 1'b0;
        check("t6_underrun_cleared", bus.underrun, 0);
        repeat (10) tick();

        // Asynchronous reset at the fourth word, then a fresh burst.
        cap.delete();
        for (int i = 0; i < 8; i++) push_word(DW'(12'h040 + i));
        wait_writes(4, 100, "t5_four_words");
        nReset = 1'b0;
        #1;
        check("t5_async_hostWrite", bus.hostWrite, 0);
        check("t5_async_hostData", bus.hostData, 0);
        check("t5_async_fifoAck", bus.fifoAck, 0);
        repeat (2) tick();
        nReset = 1'b1;
        cap.delete();
        for (int i = 8; i < 16; i++) push_word(DW'(12'h040 + i));
        wait_cap(8, 100, "t5_fresh_burst");
        repeat (10) tick();
        check("t5_exactly_eight", cap.size(), 8);
        if (cap.size() >= 8) begin
            check("t5_first_word", cap[0][BW-1:0], 16'h0044);
            check("t5_last_end", cap[7], {1'b1, 16'h004B});
        end

        // Test mode with an empty FIFO, through the counter wrap.
        env_q.delete();
        exp_q.delete();
        cap.delete();
        bus.testMode = 1'b1;
        wait_cap(16, 100, "t4_first_bursts");
        if (cap.size() >= 16) begin
            for (int i = 0; i < 16; i++) check("t4_pattern", cap[i], {(i % 8 == 7), 16'(i)});
        end
        wait_cap(1030, 2500, "t4_wrap_reached");
        if (cap.size() >= 1030) begin
            check("t4_before_wrap", cap[1023][BW-1:0], 16'h03FF);
            check("t4_after_wrap", cap[1024][BW-1:0], 16'h0000);
        end
        bus.testMode = 1'b0;
        repeat (20) tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            bus.hostReady   = ($urandom_range(0, 3) != 0);
            bus.clearErrors = ($urandom_range(0, 15) == 0);
            force_hf        = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) bus.testMode = ~bus.testMode;
            if ($urandom_range(0, 7) == 0 && env_q.size() < 40) begin
                int n = $urandom_range(1, 12);
                for (int k = 0; k < n; k++) push_word(DW'($urandom));
            end
        end
        force_hf = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
